mem_wb_stage: RTL and testbench

MEM/WB pipeline register plus writeback stage of the CPU. It sits directly downstream of the memory stage and captures the memory read word, the ALU/JAL/LUI result and the destination register. It performs load byte/half extraction and sign extension, then drives the register-file write port. It also generates the writeback-to-store forwarding select (wb_data/wb_forward) that the memory stage consumes, and keeps a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 159 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register plus writeback stage.
//
// Captures the instruction leaving the memory stage and extracts the load
// byte or half. It drives the register-file write port and the writeback to
// store-data forwarding select, and counts retired instructions.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   stall_mem, flush    MEM stalled / kill the incoming instruction (both bubble)
//   m_*                 control and operands of the instruction currently in MEM
//   read_data_MEMWB     data-memory read word for a load in MEM
//   reg_data_MEMWB      non-load result (pc+4 / imm / alu_out)
//   wb_RegWrite/wb_rd/wb_data   register-file write port
//   wb_forward          store in MEM must take wb_data as its store data
//   misalign_err        high for the WB cycle of a misaligned load
//   instret             retired-instruction counter (wraps)
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_mem,
  input  logic             flush,
  input  logic             m_valid,
  input  logic             m_RegWrite,
  input  logic             m_MemToReg,
  input  logic             m_MemWrite,
  input  logic [2:0]       m_funct3,
  input  logic [1:0]       m_addr_lo,
  input  logic [4:0]       m_rd,
  input  logic [4:0]       m_rs2,
  input  logic [XLEN-1:0]  read_data_MEMWB,
  input  logic [XLEN-1:0]  reg_data_MEMWB,
  output logic             wb_RegWrite,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_forward,
  output logic             misalign_err,
  output logic [CNT_W-1:0] instret
);

  logic             wb_valid_r;
  logic             reg_write_r;
  logic             mem_to_reg_r;
  logic [2:0]       funct3_r;
  logic [1:0]       addr_lo_r;
  logic [4:0]       rd_r;
  logic [XLEN-1:0]  read_word_r;
  logic [XLEN-1:0]  reg_data_r;
  logic [CNT_W-1:0] instret_r;

  logic             misaligned_s;
  logic [XLEN-1:0]  load_val_s;
  logic             reg_write_s;
  logic [XLEN-1:0]  wb_data_s;
  logic             forward_s;

  // Byte/half extraction with sign or zero extension; unknown codes pass the word.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                   input logic [1:0] lo,
                                                   input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] r;
    case (lo)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      2'b11:   b = w[31:24];
      default: b = w[7:0];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // A load is misaligned when a half access is on an odd byte or a word access is off 4-byte.
  function automatic logic load_misaligned(input logic mem_to_reg,
                                           input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic m;
    case (f3)
      3'b001, 3'b101: m = lo[0];
      3'b010:         m = (lo != 2'b00);
      default:        m = 1'b0;
    endcase
    return mem_to_reg & m;
  endfunction

  // MEM->WB pipeline register; a flush or stall inserts a bubble and holds the payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_r   <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
      funct3_r     <= 3'b000;
      addr_lo_r    <= 2'b00;
      rd_r         <= 5'd0;
      read_word_r  <= '0;
      reg_data_r   <= '0;
    end else if (flush || stall_mem) begin
      wb_valid_r   <= 1'b0;
    end else begin
      wb_valid_r   <= m_valid;
      reg_write_r  <= m_RegWrite;
      mem_to_reg_r <= m_MemToReg;
      funct3_r     <= m_funct3;
      addr_lo_r    <= m_addr_lo;
      rd_r         <= m_rd;
      read_word_r  <= read_data_MEMWB;
      reg_data_r   <= reg_data_MEMWB;
    end
  end

  // Retire counter: every valid WB cycle counts once, since a stall turns the next cycle into a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_r <= '0;
    end else if (wb_valid_r) begin
      instret_r <= instret_r + CNT_W'(1);
    end else begin
      instret_r <= instret_r;
    end
  end

  // Writeback data select, write enable and store-data forwarding.
  always_comb begin
    misaligned_s = 1'b0;
    load_val_s   = '0;
    reg_write_s  = 1'b0;
    wb_data_s    = '0;
    forward_s    = 1'b0;
    misaligned_s = wb_valid_r & load_misaligned(mem_to_reg_r, funct3_r, addr_lo_r);
    load_val_s   = load_extract(funct3_r, addr_lo_r, read_word_r);
    if (mem_to_reg_r) begin
      wb_data_s = load_val_s;
    end else begin
      wb_data_s = reg_data_r;
    end
    reg_write_s = wb_valid_r & reg_write_r & (rd_r != 5'd0) & ~misaligned_s;
    // rd_r != 0 is already folded into reg_write_s, so m_rs2 == 0 never forwards.
    forward_s   = reg_write_s & m_MemWrite & (rd_r == m_rs2);
  end

  assign wb_RegWrite  = reg_write_s;
  assign wb_rd        = rd_r;
  assign wb_data      = wb_data_s;
  assign wb_forward   = forward_s;
  assign misalign_err = misaligned_s;
  assign instret      = instret_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table-driven vectors plus hand-written
// sequences for stall, reset mid-stream and counter wrap (CNT_W=4 instance).
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_mem, flush, m_valid, m_RegWrite, m_MemToReg, m_MemWrite;
  logic [2:0]  m_funct3;
  logic [1:0]  m_addr_lo;
  logic [4:0]  m_rd, m_rs2;
  logic [31:0] read_data_MEMWB, reg_data_MEMWB;

  logic        wb_RegWrite, wb_forward, misalign_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] instret;

  logic        s_wb_RegWrite, s_wb_forward, s_misalign_err;
  logic [4:0]  s_wb_rd;
  logic [31:0] s_wb_data;
  logic [3:0]  s_instret;

  mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_mem(stall_mem), .flush(flush),
    .m_valid(m_valid), .m_RegWrite(m_RegWrite), .m_MemToReg(m_MemToReg),
    .m_MemWrite(m_MemWrite), .m_funct3(m_funct3), .m_addr_lo(m_addr_lo),
    .m_rd(m_rd), .m_rs2(m_rs2), .read_data_MEMWB(read_data_MEMWB),
    .reg_data_MEMWB(reg_data_MEMWB), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_forward(wb_forward), .misalign_err(misalign_err),
    .instret(instret)
  );

  mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .stall_mem(stall_mem), .flush(flush),
    .m_valid(m_valid), .m_RegWrite(m_RegWrite), .m_MemToReg(m_MemToReg),
    .m_MemWrite(m_MemWrite), .m_funct3(m_funct3), .m_addr_lo(m_addr_lo),
    .m_rd(m_rd), .m_rs2(m_rs2), .read_data_MEMWB(read_data_MEMWB),
    .reg_data_MEMWB(reg_data_MEMWB), .wb_RegWrite(s_wb_RegWrite), .wb_rd(s_wb_rd),
    .wb_data(s_wb_data), .wb_forward(s_wb_forward), .misalign_err(s_misalign_err),
    .instret(s_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid, rw, m2r, mw;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [4:0]  rd, rs2;
    logic [31:0] rdata, regd;
    logic        fl, st;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_fwd, e_mis, chk;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_instret = 32'd0;
  logic        model_valid = 1'b0;
  logic [31:0] saved;

  localparam logic [31:0] W = 32'h80FF7F01;
  localparam logic [31:0] R = 32'hDEADBEEF;

  vec_t tbl[17];

  function automatic vec_t mk(string n, logic v, logic rw, logic m2r, logic mw,
                              logic [2:0] f3, logic [1:0] lo, logic [4:0] rd,
                              logic [4:0] rs2, logic [31:0] rdata, logic [31:0] regd,
                              logic fl, logic st, logic e_rw, logic [4:0] e_rd,
                              logic [31:0] e_data, logic e_fwd, logic e_mis, logic chk);
    vec_t x;
    x.name = n; x.valid = v; x.rw = rw; x.m2r = m2r; x.mw = mw; x.f3 = f3; x.lo = lo;
    x.rd = rd; x.rs2 = rs2; x.rdata = rdata; x.regd = regd; x.fl = fl; x.st = st;
    x.e_rw = e_rw; x.e_rd = e_rd; x.e_data = e_data; x.e_fwd = e_fwd; x.e_mis = e_mis;
    x.chk = chk;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one MEM-stage instruction at the negedge, clock it, then check at the
  // following negedge. m_MemWrite/m_rs2 stay applied during the check so they
  // act as the store currently in MEM for the forwarding compare.
  task automatic apply(input vec_t v);
    m_valid = v.valid; m_RegWrite = v.rw; m_MemToReg = v.m2r; m_MemWrite = v.mw;
    m_funct3 = v.f3; m_addr_lo = v.lo; m_rd = v.rd; m_rs2 = v.rs2;
    read_data_MEMWB = v.rdata; reg_data_MEMWB = v.regd; flush = v.fl; stall_mem = v.st;
    @(posedge clk);
    exp_instret = exp_instret + {31'd0, model_valid};
    model_valid = v.valid & ~v.fl & ~v.st;
    @(negedge clk);
    check({v.name, ".wb_RegWrite"}, {31'd0, wb_RegWrite}, {31'd0, v.e_rw});
    check({v.name, ".wb_forward"}, {31'd0, wb_forward}, {31'd0, v.e_fwd});
    check({v.name, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, v.e_mis});
    check({v.name, ".instret"}, instret, exp_instret);
    check({v.name, ".instret4"}, {28'd0, s_instret}, {28'd0, exp_instret[3:0]});
    if (v.chk) begin
      check({v.name, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, v.e_rd});
      check({v.name, ".wb_data"}, wb_data, v.e_data);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".wb_RegWrite"}, {31'd0, wb_RegWrite}, 32'd0);
    check({name, ".wb_rd"}, {27'd0, wb_rd}, 32'd0);
    check({name, ".wb_data"}, wb_data, 32'd0);
    check({name, ".wb_forward"}, {31'd0, wb_forward}, 32'd0);
    check({name, ".misalign_err"}, {31'd0, misalign_err}, 32'd0);
    check({name, ".instret"}, instret, 32'd0);
    check({name, ".instret4"}, {28'd0, s_instret}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    exp_instret = 32'd0;
    model_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    //           name     v     rw    m2r   mw    f3      lo     rd     rs2    rdata  regd          fl    st    e_rw  e_rd   e_data          fwd   mis   chk
    tbl[0]  = mk("alu",   1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd5,  5'd0, W, 32'h12345678, 1'b0, 1'b0, 1'b1, 5'd5,  32'h12345678, 1'b0, 1'b0, 1'b1);
    tbl[1]  = mk("lb3",   1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 2'd3, 5'd1,  5'd0, W, R,            1'b0, 1'b0, 1'b1, 5'd1,  32'hFFFFFF80, 1'b0, 1'b0, 1'b1);
    tbl[2]  = mk("lbu2",  1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 2'd2, 5'd2,  5'd0, W, R,            1'b0, 1'b0, 1'b1, 5'd2,  32'h000000FF, 1'b0, 1'b0, 1'b1);
    tbl[3]  = mk("lh2",   1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 2'd2, 5'd3,  5'd0, W, R,            1'b0, 1'b0, 1'b1, 5'd3,  32'hFFFF80FF, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk("lhu0",  1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 2'd0, 5'd4,  5'd0, W, R,            1'b0, 1'b0, 1'b1, 5'd4,  32'h00007F01, 1'b0, 1'b0, 1'b1);
    tbl[5]  = mk("lw0",   1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 2'd0, 5'd6,  5'd0, W, R,            1'b0, 1'b0, 1'b1, 5'd6,  32'h80FF7F01, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk("lw2mis",1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 2'd2, 5'd6,  5'd0, W, R,            1'b0, 1'b0, 1'b0, 5'd6,  32'h0,        1'b0, 1'b1, 1'b0);
    tbl[7]  = mk("lh1mis",1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 2'd1, 5'd6,  5'd0, W, R,            1'b0, 1'b0, 1'b0, 5'd6,  32'h0,        1'b0, 1'b1, 1'b0);
    tbl[8]  = mk("lb1",   1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 5'd9,  5'd0, W, R,            1'b0, 1'b0, 1'b1, 5'd9,  32'h0000007F, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk("fwd7",  1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 5'd7,  5'd7, W, 32'hAAAA5555, 1'b0, 1'b0, 1'b1, 5'd7,  32'hAAAA5555, 1'b1, 1'b0, 1'b1);
    tbl[10] = mk("fwd8",  1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 5'd7,  5'd8, W, 32'hAAAA5555, 1'b0, 1'b0, 1'b1, 5'd7,  32'hAAAA5555, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk("fwdx0", 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 5'd0,  5'd0, W, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 5'd0,  32'hAAAA5555, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk("fwdnmw",1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd7,  5'd7, W, 32'hAAAA5555, 1'b0, 1'b0, 1'b1, 5'd7,  32'hAAAA5555, 1'b0, 1'b0, 1'b1);
    tbl[13] = mk("bubble",1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd10, 5'd0, W, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 5'd10, 32'h0,        1'b0, 1'b0, 1'b0);
    tbl[14] = mk("flush", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd11, 5'd0, W, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 5'd11, 32'h0,        1'b0, 1'b0, 1'b0);
    tbl[15] = mk("store", 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 2'd2, 5'd12, 5'd3, W, 32'h00000102, 1'b0, 1'b0, 1'b0, 5'd12, 32'h00000102, 1'b0, 1'b0, 1'b1);
    tbl[16] = mk("f3_011",1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 2'd0, 5'd12, 5'd0, W, R,            1'b0, 1'b0, 1'b1, 5'd12, 32'h80FF7F01, 1'b0, 1'b0, 1'b1);

    stall_mem = 1'b0; flush = 1'b0; m_valid = 1'b0; m_RegWrite = 1'b0; m_MemToReg = 1'b0;
    m_MemWrite = 1'b0; m_funct3 = 3'b000; m_addr_lo = 2'd0; m_rd = 5'd0; m_rs2 = 5'd0;
    read_data_MEMWB = 32'd0; reg_data_MEMWB = 32'd0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) apply(tbl[i]);

    // Stall: the instruction already in WB retires once, then 3 bubbles, then release.
    apply(mk("pre", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd13, 5'd0, W, 32'h00001111,
             1'b0, 1'b0, 1'b1, 5'd13, 32'h00001111, 1'b0, 1'b0, 1'b1));
    saved = exp_instret;
    for (int i = 0; i < 3; i++)
      apply(mk("stall", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd14, 5'd0, W, 32'h00002222,
               1'b0, 1'b1, 1'b0, 5'd13, 32'h0, 1'b0, 1'b0, 1'b0));
    check("stall.retire_once", instret, saved + 32'd1);
    apply(mk("release", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd14, 5'd0, W, 32'h00002222,
             1'b0, 1'b0, 1'b1, 5'd14, 32'h00002222, 1'b0, 1'b0, 1'b1));
    apply(mk("after", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd0, 5'd0, W, 32'h0,
             1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    check("release.retire_once", instret, saved + 32'd2);
    // flush and stall together: still a bubble
    apply(mk("flush_stall", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd15, 5'd0, W, 32'h3,
             1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0));

    // Reset mid-stream discards the in-flight instruction
    apply(mk("inflight", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd16, 5'd0, W, 32'h00004444,
             1'b0, 1'b0, 1'b1, 5'd16, 32'h00004444, 1'b0, 1'b0, 1'b1));
    m_MemWrite = 1'b1; m_rs2 = 5'd16;
    do_reset();
    check_all_zero("midreset");
    rst_n = 1'b1;

    // Counter wrap on the CNT_W=4 instance: 15 retires reach 4'hF, the 16th gives 0
    for (int i = 0; i < 16; i++)
      apply(mk("wrap", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd1, 5'd0, W, 32'h5,
               1'b0, 1'b0, 1'b1, 5'd1, 32'h5, 1'b0, 1'b0, 1'b1));
    check("wrap.at_max", {28'd0, s_instret}, 32'd15);
    apply(mk("wrap_end", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd0, 5'd0, W, 32'h0,
             1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    check("wrap.zero", {28'd0, s_instret}, 32'd0);
    check("wrap.full", instret, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
